conv2d_stream: RTL and testbench

Parametrised next-generation 2-D convolution engine for the image pipeline: it walks a runtime-sized image held in single-port memory, applies a loadable K×K signed kernel with zero padding and selectable stride, and writes one clamped result per output pixel. It sits between the frame memory (read side) and the result memory (write side) and is controlled by a start/ready handshake.

---
 rtl/conv2d_pkg.sv | 45 ++++
 rtl/conv2d_stream_if.sv | 37 +++
 rtl/conv2d_stream_mac.sv | 55 +++++
 rtl/conv2d_stream.sv | 198 +++++++++++++++++++
 tb/tb_conv2d_stream.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the streaming 2-D convolution engine.
package conv2d_pkg;

  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_DATA_W  = 12;
  localparam int DEF_COEF_W  = 8;
  localparam int DEF_K       = 5;
  localparam int DEF_DIM_W   = 8;
  localparam int DEF_MEM_LAT = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] CLAMP_PASS = 2'd0;
  localparam logic [1:0] CLAMP_LO   = 2'd1;
  localparam logic [1:0] CLAMP_HI   = 2'd2;

  // Per-tap bookkeeping that rides alongside the frame-memory read.
  typedef struct packed {
    logic vld;
    logic pad;
    logic first;
    logic last;
    logic lastOut;
  } tapTag_t;

  function automatic int tapIdxW(input int k);
    return (k * k > 1) ? $clog2(k * k) : 1;
  endfunction

  function automatic logic signed [63:0] arShift(input logic signed [63:0] v, input logic [4:0] sh);
    return v >>> sh;
  endfunction

  function automatic logic [1:0] clampCode(input logic signed [63:0] v, input int dataW);
    logic signed [63:0] maxV;
    maxV = (64'sd1 <<< dataW) - 64'sd1;
    if (v < 64'sd0) return CLAMP_LO;
    if (v > maxV) return CLAMP_HI;
    return CLAMP_PASS;
  endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// Control, coefficient-load and memory-port bundle of the convolution engine.
interface conv2d_stream_if import conv2d_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int K      = DEF_K,
  parameter int DIM_W  = DEF_DIM_W
) ();
  localparam int TAP_W = tapIdxW(K);

  logic                     start;
  logic [DIM_W-1:0]         n_rows;
  logic [DIM_W-1:0]         n_cols;
  logic                     stride2;
  logic [4:0]               shift;
  logic                     coef_we;
  logic [TAP_W-1:0]         coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic [DATA_W-1:0]        d_in;
  logic [ADDR_W-1:0]        ReadAddress;
  logic                     ReadEnable;
  logic [ADDR_W-1:0]        WriteAddress;
  logic [DATA_W-1:0]        d_out;
  logic                     WriteEnable;
  logic                     busy;
  logic                     ready;

  modport master (
    output start, n_rows, n_cols, stride2, shift, coef_we, coef_addr, coef_data, d_in,
    input  ReadAddress, ReadEnable, WriteAddress, d_out, WriteEnable, busy, ready
  );

  modport slave (
    input  start, n_rows, n_cols, stride2, shift, coef_we, coef_addr, coef_data, d_in,
    output ReadAddress, ReadEnable, WriteAddress, d_out, WriteEnable, busy, ready
  );
endinterface

// File: rtl/conv2d_stream_mac.sv
// Multiply-accumulate back end: clears on the first tap of a window, emits a shifted and
// clamped result one cycle after the window's last tap.
module conv_mac import conv2d_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_DATA_W + DEF_COEF_W + 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  tapTag_t                  tag_i,
  input  logic [DATA_W-1:0]        pix_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic [4:0]               shift_i,
  output logic                     we_o,
  output logic                     final_o,
  output logic [DATA_W-1:0]        dOut_o
);
  localparam int PROD_W = DATA_W + 1 + COEF_W;

  logic signed [DATA_W:0]   pixS;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [63:0]       shifted;
  logic [1:0]               code;
  logic [DATA_W-1:0]        result_d, dOut_q;
  logic                     we_q, final_q;

  // Padded taps read nothing, so whatever sits on the data bus is forced to zero here.
  always_comb begin
    pixS     = tag_i.pad ? '0 : $signed({1'b0, pix_i});
    prod     = pixS * coef_i;
    acc_d    = (tag_i.first ? '0 : acc_q) + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    shifted  = arShift({{(64-ACC_W){acc_d[ACC_W-1]}}, acc_d}, shift_i);
    code     = clampCode(shifted, DATA_W);
    result_d = (code == CLAMP_LO) ? '0 : (code == CLAMP_HI) ? '1 : shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      dOut_q  <= '0;
      we_q    <= 1'b0;
      final_q <= 1'b0;
    end else begin
      we_q    <= tag_i.vld && tag_i.last;
      final_q <= tag_i.vld && tag_i.last && tag_i.lastOut;
      if (tag_i.vld) acc_q <= acc_d;
      if (tag_i.vld && tag_i.last) dOut_q <= result_d;
    end
  end

  assign we_o    = we_q;
  assign final_o = final_q;
  assign dOut_o  = dOut_q;
endmodule

// File: rtl/conv2d_stream.sv
// K x K zero-padded convolution walker: issues one tap read per cycle, tracks taps through the
// frame-memory latency and hands them to conv_mac for accumulation and write-back.
module conv2d_stream import conv2d_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int COEF_W  = DEF_COEF_W,
  parameter int K       = DEF_K,
  parameter int DIM_W   = DEF_DIM_W,
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int ACC_W   = DATA_W + COEF_W + 6
) (
  input logic             clk,
  input logic             rst,
  conv2d_stream_if.slave  bus
);
  localparam int TAP_W = tapIdxW(K);
  localparam int NTAP  = K * K;
  localparam int KC_W  = $clog2(K);
  localparam int OFF_W = DIM_W + 3;
  localparam int AF_W  = 2 * DIM_W + 1;
  localparam logic signed [OFF_W-1:0] HALF = OFF_W'(K / 2);

  logic [1:0]               state_q, state_d;
  logic [DIM_W-1:0]         nRows_q, nCols_q, outRows_q, outCols_q;
  logic                     stride2_q;
  logic [4:0]               shift_q;
  logic [DIM_W-1:0]         row_q, row_d, col_q, col_d;
  logic [KC_W-1:0]          kr_q, kr_d, kc_q, kc_d;
  logic [TAP_W-1:0]         tap_q, tap_d;
  logic [ADDR_W-1:0]        wrCnt_q;
  logic signed [COEF_W-1:0] coefs_q [NTAP];
  tapTag_t                  tagPipe_q [MEM_LAT];
  logic [TAP_W-1:0]         idxPipe_q [MEM_LAT];

  logic                     run, busy, accept, zeroDim;
  logic                     lastTap, lastCol, lastRow, inImage, readEn;
  logic [DIM_W:0]           rowBase, colBase;
  logic signed [OFF_W-1:0]  rowIn, colIn;
  logic [AF_W-1:0]          addrFull;
  tapTag_t                  newTag;
  logic                     macWe, macFinal;
  logic [DATA_W-1:0]        macOut;

  assign run     = (state_q == ST_RUN);
  assign busy    = run || (state_q == ST_DRAIN);
  assign accept  = bus.start && !busy;
  assign zeroDim = (bus.n_rows == '0) || (bus.n_cols == '0);
  assign lastTap = (tap_q == TAP_W'(NTAP - 1));
  assign lastCol = (col_q == outCols_q - DIM_W'(1));
  assign lastRow = (row_q == outRows_q - DIM_W'(1));

  // Input pixel under the current tap; negative or past-the-edge positions are padding.
  always_comb begin
    rowBase  = stride2_q ? {row_q, 1'b0} : {1'b0, row_q};
    colBase  = stride2_q ? {col_q, 1'b0} : {1'b0, col_q};
    rowIn    = $signed({2'b00, rowBase}) + $signed(OFF_W'(kr_q)) - HALF;
    colIn    = $signed({2'b00, colBase}) + $signed(OFF_W'(kc_q)) - HALF;
    inImage  = !rowIn[OFF_W-1] && !colIn[OFF_W-1] &&
               (rowIn < $signed({3'b000, nRows_q})) && (colIn < $signed({3'b000, nCols_q}));
    addrFull = AF_W'(rowIn[DIM_W-1:0]) * AF_W'(nCols_q) + AF_W'(colIn[DIM_W-1:0]);
    readEn   = run && inImage;
    newTag   = '{vld: run, pad: !inImage, first: (tap_q == '0), last: lastTap,
                 lastOut: lastTap && lastCol && lastRow};
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    tap_d   = tap_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          row_d   = '0;
          col_d   = '0;
          kr_d    = '0;
          kc_d    = '0;
          tap_d   = '0;
          state_d = zeroDim ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (kc_q == KC_W'(K - 1)) begin
          kc_d = '0;
          kr_d = (kr_q == KC_W'(K - 1)) ? '0 : kr_q + KC_W'(1);
        end else begin
          kc_d = kc_q + KC_W'(1);
        end
        tap_d = lastTap ? '0 : tap_q + TAP_W'(1);
        if (lastTap) begin
          if (lastCol) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
          if (lastCol && lastRow) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (macFinal) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      tap_q   <= tap_d;
    end
  end

  // Frame configuration is captured once per accepted start so a running frame is immune to input changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      nRows_q   <= '0;
      nCols_q   <= '0;
      outRows_q <= '0;
      outCols_q <= '0;
      stride2_q <= 1'b0;
      shift_q   <= '0;
      wrCnt_q   <= '0;
    end else begin
      if (accept) begin
        nRows_q   <= bus.n_rows;
        nCols_q   <= bus.n_cols;
        stride2_q <= bus.stride2;
        shift_q   <= bus.shift;
        outRows_q <= bus.stride2 ? ({1'b0, bus.n_rows[DIM_W-1:1]} + DIM_W'(bus.n_rows[0])) : bus.n_rows;
        outCols_q <= bus.stride2 ? ({1'b0, bus.n_cols[DIM_W-1:1]} + DIM_W'(bus.n_cols[0])) : bus.n_cols;
        wrCnt_q   <= '0;
      end else if (macWe) begin
        wrCnt_q   <= wrCnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) coefs_q[i] <= '0;
    end else if (bus.coef_we && !busy && (32'(bus.coef_addr) < NTAP)) begin
      coefs_q[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Tap tags are delayed by exactly the memory latency so they meet their pixel at the MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        tagPipe_q[i] <= '0;
        idxPipe_q[i] <= '0;
      end
    end else begin
      tagPipe_q[0] <= newTag;
      idxPipe_q[0] <= tap_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        tagPipe_q[i] <= tagPipe_q[i-1];
        idxPipe_q[i] <= idxPipe_q[i-1];
      end
    end
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .tag_i   (tagPipe_q[MEM_LAT-1]),
    .pix_i   (bus.d_in),
    .coef_i  (coefs_q[idxPipe_q[MEM_LAT-1]]),
    .shift_i (shift_q),
    .we_o    (macWe),
    .final_o (macFinal),
    .dOut_o  (macOut)
  );

  assign bus.ReadEnable   = readEn;
  assign bus.ReadAddress  = readEn ? ADDR_W'(addrFull) : '0;
  assign bus.WriteEnable  = macWe;
  assign bus.d_out        = macOut;
  assign bus.WriteAddress = wrCnt_q;
  assign bus.busy         = busy;
  assign bus.ready        = (state_q == ST_DONE);
endmodule

// File: tb/tb_conv2d_stream.sv
// Randomised bench for conv2d_stream (K=3, MEM_LAT=1) against a direct-sum convolution model.
module tb_conv2d_stream;
  localparam int AW = 17;
  localparam int DW = 12;
  localparam int CW = 8;
  localparam int KK = 3;
  localparam int DIMW = 8;
  localparam int ML = 1;
  localparam int NT = KK * KK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv2d_stream_if #(.ADDR_W(AW), .DATA_W(DW), .COEF_W(CW), .K(KK), .DIM_W(DIMW)) bus ();

  conv2d_stream #(.ADDR_W(AW), .DATA_W(DW), .COEF_W(CW), .K(KK), .DIM_W(DIMW), .MEM_LAT(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdPipe [ML];
  int coefTb [NT];
  int expQ[$];
  int expReads;
  int wrAddr[$], wrData[$], wrCyc[$];
  int readCount, badRead, readyCyc, startCyc, curLimit;
  bit busyAt1, readyAt1;

  // Frame memory with MEM_LAT cycles of read latency; junk is returned when no read is issued.
  always @(posedge clk) begin
    rdPipe[0] <= bus.ReadEnable ? mem[bus.ReadAddress] : DW'($urandom);
    for (int i = 1; i < ML; i++) rdPipe[i] <= rdPipe[i-1];
    cyc <= cyc + 1;
  end
  assign bus.d_in = rdPipe[ML-1];

  always @(negedge clk) begin
    if (bus.WriteEnable) begin
      wrAddr.push_back(int'(bus.WriteAddress));
      wrData.push_back(int'(bus.d_out));
      wrCyc.push_back(cyc - startCyc);
    end
    if (bus.ReadEnable) begin
      readCount++;
      if (int'(bus.ReadAddress) >= curLimit) badRead++;
    end
    if (bus.ready && readyCyc < 0 && (cyc - startCyc) >= 1) readyCyc = cyc - startCyc;
  end

  task automatic buildModel(input int nr, input int nc, input int s2, input int sh);
    int s, oR, oC, ir, ic;
    longint acc, res;
    expQ.delete();
    expReads = 0;
    s = s2 ? 2 : 1;
    oR = (nr + s - 1) / s;
    oC = (nc + s - 1) / s;
    for (int r = 0; r < oR; r++)
      for (int c = 0; c < oC; c++) begin
        acc = 0;
        for (int kr = -KK/2; kr <= KK/2; kr++)
          for (int kc = -KK/2; kc <= KK/2; kc++) begin
            ir = r * s + kr;
            ic = c * s + kc;
            if (ir >= 0 && ir < nr && ic >= 0 && ic < nc) begin
              acc += longint'(mem[ir * nc + ic]) * longint'(coefTb[(kr + KK/2) * KK + kc + KK/2]);
              expReads++;
            end
          end
        res = acc >>> sh;
        if (res < 0) res = 0;
        if (res > 4095) res = 4095;
        expQ.push_back(int'(res));
      end
  endtask

  task automatic loadCoefs();
    for (int i = 0; i < NT; i++) begin
      @(negedge clk);
      bus.coef_we = 1'b1;
      bus.coef_addr = 4'(i);
      bus.coef_data = 8'(coefTb[i]);
    end
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic applyStimulus(input int nr, input int nc, input int s2, input int sh, output bit timedOut);
    @(negedge clk);
    wrAddr.delete(); wrData.delete(); wrCyc.delete();
    readCount = 0; badRead = 0; readyCyc = -1;
    curLimit = nr * nc;
    bus.n_rows = 8'(nr); bus.n_cols = 8'(nc); bus.stride2 = s2[0]; bus.shift = 5'(sh);
    bus.start = 1'b1;
    startCyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    busyAt1 = bus.busy;
    readyAt1 = bus.ready;
    for (int i = 0; i < 3000 && !bus.ready; i++) @(negedge clk);
    timedOut = !bus.ready;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.ReadAddress !== '0) begin errors++; $display("[TB] FAIL reset_raddr: got %0d expected 0", bus.ReadAddress); end
    checks++; if (bus.ReadEnable !== 1'b0) begin errors++; $display("[TB] FAIL reset_ren: got %b expected 0", bus.ReadEnable); end
    checks++; if (bus.WriteAddress !== '0) begin errors++; $display("[TB] FAIL reset_waddr: got %0d expected 0", bus.WriteAddress); end
    checks++; if (bus.d_out !== '0) begin errors++; $display("[TB] FAIL reset_dout: got %0d expected 0", bus.d_out); end
    checks++; if (bus.WriteEnable !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen: got %b expected 0", bus.WriteEnable); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.ready); end
    rst = 1'b0;
  endtask

  task automatic test_box();
    bit to;
    for (int i = 0; i < 16; i++) mem[i] = 12'd10;
    for (int i = 0; i < NT; i++) coefTb[i] = 1;
    loadCoefs();
    buildModel(4, 4, 0, 0);
    applyStimulus(4, 4, 0, 0, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL box_timeout: ready never rose"); end
    checks++; if (busyAt1 !== 1'b1) begin errors++; $display("[TB] FAIL box_busy1: got %b expected 1", busyAt1); end
    checks++; if (wrData.size() != 16) begin errors++; $display("[TB] FAIL box_count: got %0d expected 16", wrData.size()); end
    if (wrData.size() > 5) begin
      checks++; if (wrData[0] != 40) begin errors++; $display("[TB] FAIL box_out0: got %0d expected 40", wrData[0]); end
      checks++; if (wrData[1] != 60) begin errors++; $display("[TB] FAIL box_out1: got %0d expected 60", wrData[1]); end
      checks++; if (wrData[5] != 90) begin errors++; $display("[TB] FAIL box_out5: got %0d expected 90", wrData[5]); end
    end
    for (int i = 0; i < wrData.size() && i < expQ.size(); i++) begin
      checks++; if (wrData[i] != expQ[i]) begin errors++; $display("[TB] FAIL box_data[%0d]: got %0d expected %0d", i, wrData[i], expQ[i]); end
      checks++; if (wrCyc[i] != (i + 1) * NT + ML + 1) begin errors++; $display("[TB] FAIL box_wcyc[%0d]: got %0d expected %0d", i, wrCyc[i], (i + 1) * NT + ML + 1); end
    end
    checks++; if (readyCyc != 16 * NT + ML + 2) begin errors++; $display("[TB] FAIL box_ready_cyc: got %0d expected %0d", readyCyc, 16 * NT + ML + 2); end
  endtask

  task automatic test_identity();
    bit to;
    int base;
    base = int'($urandom_range(0, 4095));
    for (int i = 0; i < 35; i++) mem[i] = 12'((base + i * 117) % 4096);
    for (int i = 0; i < NT; i++) coefTb[i] = (i == NT / 2) ? 16 : 0;
    loadCoefs();
    applyStimulus(5, 7, 0, 4, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL ident_timeout: ready never rose"); end
    checks++; if (wrData.size() != 35) begin errors++; $display("[TB] FAIL ident_count: got %0d expected 35", wrData.size()); end
    for (int i = 0; i < wrData.size() && i < 35; i++) begin
      checks++; if (wrData[i] != int'(mem[i])) begin errors++; $display("[TB] FAIL ident_data[%0d]: got %0d expected %0d", i, wrData[i], mem[i]); end
      checks++; if (wrAddr[i] != i) begin errors++; $display("[TB] FAIL ident_waddr[%0d]: got %0d expected %0d", i, wrAddr[i], i); end
    end
  endtask

  task automatic test_stride();
    bit to;
    int sh;
    for (int i = 0; i < 25; i++) mem[i] = 12'($urandom);
    for (int i = 0; i < NT; i++) coefTb[i] = int'($urandom_range(0, 255)) - 128;
    sh = int'($urandom_range(0, 6));
    loadCoefs();
    buildModel(5, 5, 1, sh);
    applyStimulus(5, 5, 1, sh, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL stride_timeout: ready never rose"); end
    checks++; if (wrData.size() != 9) begin errors++; $display("[TB] FAIL stride_count: got %0d expected 9", wrData.size()); end
    checks++; if (readCount != expReads) begin errors++; $display("[TB] FAIL stride_reads: got %0d expected %0d", readCount, expReads); end
    checks++; if (badRead != 0) begin errors++; $display("[TB] FAIL stride_badread: got %0d expected 0", badRead); end
    for (int i = 0; i < wrData.size() && i < expQ.size(); i++) begin
      checks++; if (wrData[i] != expQ[i] || wrAddr[i] != i) begin errors++; $display("[TB] FAIL stride_out[%0d]: got %0d@%0d expected %0d@%0d", i, wrData[i], wrAddr[i], expQ[i], i); end
    end
  endtask

  task automatic test_saturate();
    bit to;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 12; i++) mem[i] = 12'd4095;
      for (int i = 0; i < NT; i++) coefTb[i] = (pass == 0) ? 127 : -1;
      loadCoefs();
      applyStimulus(3, 4, 0, 0, to);
      checks++; if (to || wrData.size() != 12) begin errors++; $display("[TB] FAIL sat_count[%0d]: got %0d expected 12", pass, wrData.size()); end
      for (int i = 0; i < wrData.size(); i++) begin
        checks++; if (wrData[i] != ((pass == 0) ? 4095 : 0)) begin errors++; $display("[TB] FAIL sat_data[%0d][%0d]: got %0d expected %0d", pass, i, wrData[i], (pass == 0) ? 4095 : 0); end
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit to;
    for (int i = 0; i < 20; i++) mem[i] = 12'($urandom);
    for (int i = 0; i < NT; i++) coefTb[i] = int'($urandom_range(0, 255)) - 128;
    loadCoefs();
    buildModel(4, 5, 0, 3);
    fork
      applyStimulus(4, 5, 0, 3, to);
      begin
        repeat (12) @(negedge clk);
        bus.start = 1'b1; bus.n_rows = 8'd2; bus.coef_we = 1'b1; bus.coef_addr = 4'd4; bus.coef_data = 8'd99;
        @(negedge clk);
        bus.start = 1'b0; bus.coef_we = 1'b0;
      end
    join
    checks++; if (to || wrData.size() != expQ.size()) begin errors++; $display("[TB] FAIL busy_count: got %0d expected %0d", wrData.size(), expQ.size()); end
    for (int i = 0; i < wrData.size() && i < expQ.size(); i++) begin
      checks++; if (wrData[i] != expQ[i]) begin errors++; $display("[TB] FAIL busy_data[%0d]: got %0d expected %0d", i, wrData[i], expQ[i]); end
    end
    applyStimulus(4, 5, 0, 3, to);
    checks++; if (to || wrData.size() != expQ.size() || wrData[2] != expQ[2]) begin errors++; $display("[TB] FAIL busy_coef_kept: got %0d expected %0d", (wrData.size() > 2) ? wrData[2] : -1, expQ[2]); end
  endtask

  task automatic test_reset_midframe();
    bit to;
    for (int i = 0; i < 36; i++) mem[i] = 12'($urandom);
    @(negedge clk);
    bus.n_rows = 8'd6; bus.n_cols = 8'd6; bus.stride2 = 1'b0; bus.shift = 5'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_flags: got busy=%b ready=%b expected 0/0", bus.busy, bus.ready); end
    checks++; if (bus.ReadEnable !== 1'b0 || bus.ReadAddress !== '0) begin errors++; $display("[TB] FAIL mid_read: got en=%b addr=%0d expected 0/0", bus.ReadEnable, bus.ReadAddress); end
    checks++; if (bus.WriteEnable !== 1'b0 || bus.WriteAddress !== '0 || bus.d_out !== '0) begin errors++; $display("[TB] FAIL mid_write: got we=%b wa=%0d d=%0d expected 0/0/0", bus.WriteEnable, bus.WriteAddress, bus.d_out); end
    rst = 1'b0;
    for (int i = 0; i < NT; i++) coefTb[i] = 0;
    buildModel(6, 6, 0, 2);
    applyStimulus(6, 6, 0, 2, to);
    checks++; if (to || wrData.size() != 36) begin errors++; $display("[TB] FAIL mid_zero_count: got %0d expected 36", wrData.size()); end
    for (int i = 0; i < wrData.size(); i++) begin
      checks++; if (wrData[i] != 0) begin errors++; $display("[TB] FAIL mid_zero[%0d]: got %0d expected 0", i, wrData[i]); end
    end
    for (int i = 0; i < NT; i++) coefTb[i] = int'($urandom_range(0, 255)) - 128;
    loadCoefs();
    buildModel(6, 6, 0, 2);
    applyStimulus(6, 6, 0, 2, to);
    checks++; if (to || wrData.size() != 36) begin errors++; $display("[TB] FAIL mid_rerun_count: got %0d expected 36", wrData.size()); end
    for (int i = 0; i < wrData.size() && i < expQ.size(); i++) begin
      checks++; if (wrData[i] != expQ[i]) begin errors++; $display("[TB] FAIL mid_rerun[%0d]: got %0d expected %0d", i, wrData[i], expQ[i]); end
    end
  endtask

  task automatic test_empty();
    bit to;
    int sh;
    applyStimulus(3, 0, 0, 0, to);
    checks++; if (to || readyCyc != 1) begin errors++; $display("[TB] FAIL empty_ready: got cycle %0d expected 1", readyCyc); end
    checks++; if (wrData.size() != 0 || readCount != 0) begin errors++; $display("[TB] FAIL empty_activity: got %0d writes %0d reads expected 0/0", wrData.size(), readCount); end
    mem[0] = 12'($urandom);
    for (int i = 0; i < NT; i++) coefTb[i] = int'($urandom_range(0, 255)) - 128;
    sh = int'($urandom_range(0, 3));
    loadCoefs();
    buildModel(1, 1, 0, sh);
    applyStimulus(1, 1, 0, sh, to);
    checks++; if (to || wrData.size() != 1) begin errors++; $display("[TB] FAIL one_count: got %0d expected 1", wrData.size()); end
    checks++; if (wrData.size() > 0 && wrData[0] != expQ[0]) begin errors++; $display("[TB] FAIL one_data: got %0d expected %0d", wrData[0], expQ[0]); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int nr, nc, s2, sh;
    for (int i = 0; i < 64; i++) mem[i] = 12'($urandom);
    for (int f = 0; f < 3; f++) begin
      nr = int'($urandom_range(1, 6)); nc = int'($urandom_range(1, 6));
      s2 = int'($urandom_range(0, 1)); sh = int'($urandom_range(0, 5));
      buildModel(nr, nc, s2, sh);
      applyStimulus(nr, nc, s2, sh, to);
      checks++; if (busyAt1 !== 1'b1 || readyAt1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_restart[%0d]: got busy=%b ready=%b expected 1/0", f, busyAt1, readyAt1); end
      checks++; if (to || wrData.size() != expQ.size()) begin errors++; $display("[TB] FAIL b2b_count[%0d]: got %0d expected %0d", f, wrData.size(), expQ.size()); end
      checks++; if (readCount != expReads || badRead != 0) begin errors++; $display("[TB] FAIL b2b_reads[%0d]: got %0d/%0d expected %0d/0", f, readCount, badRead, expReads); end
      for (int i = 0; i < wrData.size() && i < expQ.size(); i++) begin
        checks++; if (wrData[i] != expQ[i] || wrAddr[i] != i) begin errors++; $display("[TB] FAIL b2b_out[%0d][%0d]: got %0d@%0d expected %0d@%0d", f, i, wrData[i], wrAddr[i], expQ[i], i); end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.n_rows = '0; bus.n_cols = '0; bus.stride2 = 1'b0; bus.shift = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    readyCyc = -1; startCyc = 0; curLimit = 0; readCount = 0; badRead = 0;
    rdPipe[0] = '0;
    test_reset();
    test_box();
    test_identity();
    test_stride();
    test_saturate();
    test_busy_ignore();
    test_reset_midframe();
    test_empty();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
